// File: rtl/rupt_pkg.sv
// rtl/rupt_pkg.sv - shared state encoding, channel indices and vector helper for the rupt arbiter
package rupt_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ISR  = 1'b1
    } rupt_state_e;

    localparam int MAX_RUPT = 32;

    localparam int T6RUPT   = 0;
    localparam int T5RUPT   = 1;
    localparam int T3RUPT   = 2;
    localparam int T4RUPT   = 3;
    localparam int KEYRUPT1 = 4;
    localparam int KEYRUPT2 = 5;
    localparam int UPRUPT   = 6;
    localparam int DOWNRUPT = 7;
    localparam int RADARUPT = 8;
    localparam int HANDRUPT = 9;

    // Full 32-bit result; callers truncate to their address width (modulo 2^AW).
    function automatic logic [31:0] rupt_vec_calc(input logic [31:0] base,
                                                  input logic [31:0] stride,
                                                  input logic [4:0]  id);
        return base + ({27'd0, id} * stride);
    endfunction

endpackage

// File: rtl/rupt_prio_enc.sv
// rtl/rupt_prio_enc.sv - combinational find-first-set from bit 0, index plus valid
module rupt_prio_enc #(
    parameter int N = 10
) (
    input  logic [N-1:0] in_i,
    output logic [4:0]   idx_o,
    output logic         valid_o
);

    // Scan downward so the lowest set bit is the last (winning) assignment.
    always_comb begin
        idx_o   = '0;
        valid_o = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (in_i[i]) begin
                idx_o   = 5'(i);
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rupt_priority_arbiter.sv
// rtl/rupt_priority_arbiter.sv - fixed-priority interrupt latch/arbiter with ISR tracking; optional RUPT_MASK_EN channel mask
module rupt_priority_arbiter
    import rupt_pkg::*;
#(
    parameter int              NRUPT      = 10,
    parameter int              AW         = 12,
    parameter logic [AW-1:0]   VEC_BASE   = 12'o4000,
    parameter int              VEC_STRIDE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NRUPT-1:0] req,
    input  logic             inhint,
    input  logic             ovf_hold,
    input  logic             take,
    input  logic             resume,
    input  logic             clr_all,
`ifdef RUPT_MASK_EN
    input  logic             mask_we,
    input  logic [NRUPT-1:0] mask_wd,
    output logic [NRUPT-1:0] mask,
`endif
    output logic             rupt_pend,
    output logic [4:0]       rupt_id,
    output logic [AW-1:0]    rupt_vec,
    output logic             in_isr,
    output logic [NRUPT-1:0] pend
);

    rupt_state_e      state_q, state_d;
    logic [NRUPT-1:0] pend_q, pend_d;
    logic             rupt_pend_q, rupt_pend_d;
    logic [4:0]       rupt_id_q, rupt_id_d;
    logic [AW-1:0]    rupt_vec_q, rupt_vec_d;

    logic [NRUPT-1:0] elig;
    logic [NRUPT-1:0] clr_vec;
    logic [4:0]       win_idx;
    logic             win_valid;
    logic             grant;
    logic             arb_ok;

`ifdef RUPT_MASK_EN
    logic [NRUPT-1:0] mask_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            mask_q <= '1;
        end else if (mask_we) begin
            mask_q <= mask_wd;
        end
    end

    assign elig = pend_q & mask_q;
    assign mask = mask_q;
`else
    assign elig = pend_q;
`endif

    rupt_prio_enc #(.N(NRUPT)) u_enc (
        .in_i    (elig),
        .idx_o   (win_idx),
        .valid_o (win_valid)
    );

    assign grant  = (state_q == ST_IDLE) && take && rupt_pend_q;
    // Arbitration outputs freeze from the grant cycle until the ISR ends.
    assign arb_ok = (state_q == ST_IDLE) && !grant;

    always_comb begin
        state_d     = state_q;
        clr_vec     = '0;
        rupt_id_d   = rupt_id_q;
        rupt_vec_d  = rupt_vec_q;
        rupt_pend_d = 1'b0;
        case (state_q)
            ST_IDLE: if (grant)  state_d = ST_ISR;
            ST_ISR:  if (resume) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (grant) begin
            clr_vec = NRUPT'(1) << rupt_id_q;
        end
        // A request landing on the grant cycle of the same channel survives.
        pend_d = (pend_q & ~clr_vec) | req;
        if (arb_ok && win_valid) begin
            rupt_id_d   = win_idx;
            rupt_vec_d  = AW'(rupt_vec_calc(32'(VEC_BASE), 32'(VEC_STRIDE), win_idx));
            rupt_pend_d = !inhint && !ovf_hold;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst || clr_all) begin
            state_q     <= ST_IDLE;
            pend_q      <= '0;
            rupt_pend_q <= 1'b0;
            rupt_id_q   <= '0;
            rupt_vec_q  <= VEC_BASE;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            rupt_pend_q <= rupt_pend_d;
            rupt_id_q   <= rupt_id_d;
            rupt_vec_q  <= rupt_vec_d;
        end
    end

    assign rupt_pend = rupt_pend_q;
    assign rupt_id   = rupt_id_q;
    assign rupt_vec  = rupt_vec_q;
    assign in_isr    = (state_q == ST_ISR);
    assign pend      = pend_q;

endmodule

// File: tb/tb_rupt_priority_arbiter.sv
// tb/tb_rupt_priority_arbiter.sv - table-driven bench for rupt_priority_arbiter (RUPT_MASK_EN section when defined)
module tb_rupt_priority_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  req;
    logic        inhint, ovf_hold, take, resume, clr_all;
    logic        rupt_pend;
    logic [4:0]  rupt_id;
    logic [11:0] rupt_vec;
    logic        in_isr;
    logic [9:0]  pend;
`ifdef RUPT_MASK_EN
    logic        mask_we;
    logic [9:0]  mask_wd;
    logic [9:0]  mask;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rupt_priority_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .inhint    (inhint),
        .ovf_hold  (ovf_hold),
        .take      (take),
        .resume    (resume),
        .clr_all   (clr_all),
`ifdef RUPT_MASK_EN
        .mask_we   (mask_we),
        .mask_wd   (mask_wd),
        .mask      (mask),
`endif
        .rupt_pend (rupt_pend),
        .rupt_id   (rupt_id),
        .rupt_vec  (rupt_vec),
        .in_isr    (in_isr),
        .pend      (pend)
    );

    typedef struct {
        logic        r;
        logic [9:0]  rq;
        logic        ih, ov, tk, rs, cl;
        logic        erp;
        logic [4:0]  eid;
        logic [11:0] evec;
        logic        eisr;
        logic [9:0]  ep;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic [9:0] rq, input logic ih, input logic ov,
                       input logic tk, input logic rs, input logic cl,
                       input logic erp, input logic [4:0] eid, input logic [11:0] evec,
                       input logic eisr, input logic [9:0] ep);
        vec_t v;
        v.r = r; v.rq = rq; v.ih = ih; v.ov = ov; v.tk = tk; v.rs = rs; v.cl = cl;
        v.erp = erp; v.eid = eid; v.evec = evec; v.eisr = eisr; v.ep = ep;
        tbl.push_back(v);
    endtask

    task automatic drive(input logic r, input logic [9:0] rq, input logic ih, input logic ov,
                         input logic tk, input logic rs, input logic cl);
        rst = r; req = rq; inhint = ih; ovf_hold = ov; take = tk; resume = rs; clr_all = cl;
    endtask

    // Apply at negedge, let one rising edge pass, sample 2 time units later.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic chk_all(input string name, input logic erp, input logic [4:0] eid,
                           input logic [11:0] evec, input logic eisr, input logic [9:0] ep);
        checks++;
        if ({rupt_pend, rupt_id, rupt_vec, in_isr, pend} !== {erp, eid, evec, eisr, ep}) begin
            failures++;
            $display("FAIL %s got rp=%0b id=%0d vec=%0o isr=%0b pend=%03h expected rp=%0b id=%0d vec=%0o isr=%0b pend=%03h",
                     name, rupt_pend, rupt_id, rupt_vec, in_isr, pend, erp, eid, evec, eisr, ep);
        end
    endtask

    initial begin
        bit seen;
        drive(1'b0, 10'h000, 0, 0, 0, 0, 0);
`ifdef RUPT_MASK_EN
        mask_we = 1'b0;
        mask_wd = '0;
`endif
        //   r  req     ih ov tk rs cl   rp id vec      isr pend
        add(0, 10'h3FF, 0, 0, 0, 0, 0,   0, 0, 12'h800, 0, 10'h000);
        add(0, 10'h3FF, 0, 0, 0, 0, 0,   0, 0, 12'h800, 0, 10'h000);
        add(1, 10'h3FF, 0, 0, 0, 0, 0,   0, 0, 12'h800, 0, 10'h3FF);
        add(1, 10'h000, 0, 0, 0, 0, 0,   1, 0, 12'h800, 0, 10'h3FF);
        add(1, 10'h000, 0, 0, 0, 0, 1,   0, 0, 12'h800, 0, 10'h000);
        add(1, 10'h000, 0, 0, 0, 0, 0,   0, 0, 12'h800, 0, 10'h000);
        add(1, 10'h080, 0, 0, 0, 0, 0,   0, 0, 12'h800, 0, 10'h080);
        add(1, 10'h000, 0, 0, 0, 0, 0,   1, 7, 12'h81C, 0, 10'h080);
        add(1, 10'h000, 0, 0, 1, 0, 0,   0, 7, 12'h81C, 1, 10'h000);
        add(1, 10'h004, 0, 0, 0, 0, 0,   0, 7, 12'h81C, 1, 10'h004);
        add(1, 10'h000, 0, 0, 1, 0, 0,   0, 7, 12'h81C, 1, 10'h004);
        add(1, 10'h000, 0, 0, 0, 1, 0,   0, 7, 12'h81C, 0, 10'h004);
        add(1, 10'h000, 0, 0, 0, 0, 0,   1, 2, 12'h808, 0, 10'h004);
        add(1, 10'h000, 0, 0, 1, 0, 0,   0, 2, 12'h808, 1, 10'h000);
        add(1, 10'h000, 0, 0, 0, 1, 0,   0, 2, 12'h808, 0, 10'h000);
        add(1, 10'h000, 0, 0, 0, 0, 0,   0, 2, 12'h808, 0, 10'h000);
        add(1, 10'h008, 1, 0, 0, 0, 0,   0, 2, 12'h808, 0, 10'h008);
        add(1, 10'h020, 1, 0, 0, 0, 0,   0, 3, 12'h80C, 0, 10'h028);
        add(1, 10'h000, 1, 0, 0, 0, 0,   0, 3, 12'h80C, 0, 10'h028);
        add(1, 10'h000, 0, 0, 0, 0, 0,   1, 3, 12'h80C, 0, 10'h028);
        add(1, 10'h000, 0, 0, 0, 0, 1,   0, 0, 12'h800, 0, 10'h000);
        add(1, 10'h010, 0, 0, 0, 0, 0,   0, 0, 12'h800, 0, 10'h010);
        add(1, 10'h000, 0, 0, 0, 0, 0,   1, 4, 12'h810, 0, 10'h010);
        add(1, 10'h010, 0, 0, 1, 0, 0,   0, 4, 12'h810, 1, 10'h010);
        add(1, 10'h000, 0, 0, 0, 0, 0,   0, 4, 12'h810, 1, 10'h010);
        add(1, 10'h000, 0, 0, 0, 1, 0,   0, 4, 12'h810, 0, 10'h010);
        add(1, 10'h000, 0, 0, 0, 0, 0,   1, 4, 12'h810, 0, 10'h010);
        add(1, 10'h000, 0, 0, 1, 0, 0,   0, 4, 12'h810, 1, 10'h000);
        add(1, 10'h0A1, 0, 0, 0, 0, 0,   0, 4, 12'h810, 1, 10'h0A1);
        add(1, 10'h000, 0, 0, 0, 0, 1,   0, 0, 12'h800, 0, 10'h000);
        add(1, 10'h001, 0, 1, 0, 0, 0,   0, 0, 12'h800, 0, 10'h001);
        add(1, 10'h000, 0, 1, 0, 0, 0,   0, 0, 12'h800, 0, 10'h001);
        add(1, 10'h000, 0, 1, 0, 0, 0,   0, 0, 12'h800, 0, 10'h001);
        add(1, 10'h000, 0, 0, 0, 0, 0,   1, 0, 12'h800, 0, 10'h001);
        add(1, 10'h000, 0, 0, 1, 1, 0,   0, 0, 12'h800, 1, 10'h000);
        add(1, 10'h000, 0, 0, 1, 1, 0,   0, 0, 12'h800, 0, 10'h000);
        add(1, 10'h002, 0, 0, 0, 0, 0,   0, 0, 12'h800, 0, 10'h002);
        add(1, 10'h000, 0, 0, 0, 0, 0,   1, 1, 12'h804, 0, 10'h002);
        add(1, 10'h000, 0, 0, 1, 0, 0,   0, 1, 12'h804, 1, 10'h000);
        add(0, 10'h000, 0, 0, 0, 0, 0,   0, 0, 12'h800, 0, 10'h000);
        add(1, 10'h000, 0, 0, 1, 0, 0,   0, 0, 12'h800, 0, 10'h000);

        @(negedge clk);
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].r, tbl[i].rq, tbl[i].ih, tbl[i].ov, tbl[i].tk, tbl[i].rs, tbl[i].cl);
            tick();
            chk_all($sformatf("row%0d", i), tbl[i].erp, tbl[i].eid, tbl[i].evec, tbl[i].eisr, tbl[i].ep);
            @(negedge clk);
        end

        // Lowest-priority channel: bounded wait for the request to surface.
        drive(1, 10'h200, 0, 0, 0, 0, 0);
        tick();
        @(negedge clk);
        drive(1, 10'h000, 0, 0, 0, 0, 0);
        seen = 1'b0;
        for (int c = 0; c < 8 && !seen; c++) begin
            tick();
            seen = rupt_pend;
            @(negedge clk);
        end
        chk("ch9_pend_timeout", {31'd0, seen}, 32'd1);
        chk("ch9_id", {27'd0, rupt_id}, 32'd9);
        chk("ch9_vec", {20'd0, rupt_vec}, 32'h824);

        // Repeated requests on a pending channel are absorbed: one grant only.
        drive(1, 10'h000, 0, 0, 0, 0, 1); tick(); @(negedge clk);
        drive(1, 10'h020, 0, 0, 0, 0, 0); tick(); @(negedge clk);
        drive(1, 10'h020, 0, 0, 0, 0, 0); tick(); @(negedge clk);
        drive(1, 10'h000, 0, 0, 0, 0, 0); tick(); @(negedge clk);
        chk_all("absorb_ready", 1, 5, 12'h814, 0, 10'h020);
        drive(1, 10'h000, 0, 0, 1, 0, 0); tick(); @(negedge clk);
        drive(1, 10'h000, 0, 0, 0, 1, 0); tick(); @(negedge clk);
        drive(1, 10'h000, 0, 0, 0, 0, 0); tick(); @(negedge clk);
        tick(); @(negedge clk);
        chk_all("absorb_single", 0, 5, 12'h814, 0, 10'h000);

`ifdef RUPT_MASK_EN
        chk("mask_reset", {22'd0, mask}, 32'h3FF);
        drive(1, 10'h201, 0, 0, 0, 0, 0);
        mask_we = 1'b1; mask_wd = 10'h3FE;
        tick();
        chk("mask_write", {22'd0, mask}, 32'h3FE);
        @(negedge clk);
        drive(1, 10'h000, 0, 0, 0, 0, 0);
        mask_we = 1'b0;
        tick();
        chk_all("mask_ch9", 1, 9, 12'h824, 0, 10'h201);
        @(negedge clk);
        mask_we = 1'b1; mask_wd = 10'h3FF;
        tick();
        chk_all("mask_open_lag", 1, 9, 12'h824, 0, 10'h201);
        @(negedge clk);
        mask_we = 1'b0;
        tick();
        chk_all("mask_open_ch0", 1, 0, 12'h800, 0, 10'h201);
        @(negedge clk);
        mask_we = 1'b1; mask_wd = 10'h155;
        tick(); @(negedge clk);
        mask_we = 1'b0;
        drive(1, 10'h000, 0, 0, 0, 0, 1);
        tick();
        chk("mask_keep_clr", {22'd0, mask}, 32'h155);
        @(negedge clk);
        drive(0, 10'h000, 0, 0, 0, 0, 0);
        tick();
        chk("mask_rst", {22'd0, mask}, 32'h3FF);
        @(negedge clk);
        drive(1, 10'h000, 0, 0, 0, 0, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule
